// File: rtl/complex_subtractor_pipe_if.sv
// rtl/complex_subtractor_pipe_if.sv - sample/result handshake and status bundle for the complex subtractor
interface complex_subtractor_pipe_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_real;
    logic [WIDTH-1:0]     a_imag;
    logic [WIDTH-1:0]     b_real;
    logic [WIDTH-1:0]     b_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     diff_real;
    logic [WIDTH-1:0]     diff_imag;
    logic                 out_ovf;
    logic                 ovf_sticky;
    logic [CNT_WIDTH-1:0] ovf_count;
    logic                 clear;

    modport slave (
        input  in_valid, a_real, a_imag, b_real, b_imag, out_ready, clear,
        output in_ready, out_valid, diff_real, diff_imag, out_ovf, ovf_sticky, ovf_count
    );

    modport master (
        output in_valid, a_real, a_imag, b_real, b_imag, out_ready, clear,
        input  in_ready, out_valid, diff_real, diff_imag, out_ovf, ovf_sticky, ovf_count
    );
endinterface

// File: rtl/complex_subtractor_pipe.sv
// rtl/complex_subtractor_pipe.sv - two-stage saturating complex subtractor with overflow status
module complex_subtractor_pipe #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    complex_subtractor_pipe_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 s1_valid_q;
    logic [WIDTH:0]       s1_re_q, s1_im_q;
    logic [WIDTH:0]       s1_re_d, s1_im_d;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     diff_re_q, diff_im_q;
    logic [WIDTH-1:0]     diff_re_d, diff_im_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 ovf_sticky_q;
    logic [CNT_WIDTH-1:0] ovf_count_q;
    logic                 ovf_re, ovf_im;
    logic                 adv1, adv2;
    logic                 ovf_event;

    assign adv2 = !out_valid_q || bus.out_ready;
    assign adv1 = !s1_valid_q || adv2;

    // One guard bit makes the difference exact, so saturation only needs the top two bits.
    assign s1_re_d = {bus.a_real[WIDTH-1], bus.a_real} - {bus.b_real[WIDTH-1], bus.b_real};
    assign s1_im_d = {bus.a_imag[WIDTH-1], bus.a_imag} - {bus.b_imag[WIDTH-1], bus.b_imag};

    assign ovf_re = s1_re_q[WIDTH] ^ s1_re_q[WIDTH-1];
    assign ovf_im = s1_im_q[WIDTH] ^ s1_im_q[WIDTH-1];

    always_comb begin
        diff_re_d = s1_re_q[WIDTH-1:0];
        diff_im_d = s1_im_q[WIDTH-1:0];
        if (ovf_re) diff_re_d = s1_re_q[WIDTH] ? MAX_NEG : MAX_POS;
        if (ovf_im) diff_im_d = s1_im_q[WIDTH] ? MAX_NEG : MAX_POS;
        out_ovf_d = ovf_re || ovf_im;
    end

    assign ovf_event = out_valid_q && bus.out_ready && out_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_re_q      <= '0;
            s1_im_q      <= '0;
            out_valid_q  <= 1'b0;
            diff_re_q    <= '0;
            diff_im_q    <= '0;
            out_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                diff_re_q   <= diff_re_d;
                diff_im_q   <= diff_im_d;
                out_ovf_q   <= out_ovf_d;
            end
            if (adv1) begin
                s1_valid_q <= bus.in_valid;
                s1_re_q    <= s1_re_d;
                s1_im_q    <= s1_im_d;
            end
            // A same-cycle clear wins over an overflow event; that event is lost.
            if (bus.clear) begin
                ovf_sticky_q <= 1'b0;
                ovf_count_q  <= '0;
            end else if (ovf_event) begin
                ovf_sticky_q <= 1'b1;
                if (!(&ovf_count_q)) ovf_count_q <= ovf_count_q + 1'b1;
            end
        end
    end

    assign bus.in_ready   = adv1;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff_real  = diff_re_q;
    assign bus.diff_imag  = diff_im_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.ovf_count  = ovf_count_q;
endmodule

// File: doc/complex_subtractor_pipe.md
Name: complex_subtractor_pipe

Overview:
Pipelined, saturating complex subtractor. Computes (a - b) on signed fixed-point complex samples and clamps each component to the WIDTH-bit signed range. It is the difference leg of the FFT butterfly datapath and sits beside the combinational complex adder. Valid/ready handshakes are provided on both sides, along with a per-sample overflow flag, a sticky overflow flag and a saturating overflow-event counter for debug/status.

Parameters:
WIDTH, 16, bit width of each real/imag component (signed two's complement)
CNT_WIDTH, 8, width of the overflow-event counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample this cycle
a_real  input  WIDTH  minuend real, signed
a_imag  input  WIDTH  minuend imag, signed
b_real  input  WIDTH  subtrahend real, signed
b_imag  input  WIDTH  subtrahend imag, signed
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
diff_real  output  WIDTH  saturated a_real - b_real
diff_imag  output  WIDTH  saturated a_imag - b_imag
out_ovf  output  1  either component of this result saturated
ovf_sticky  output  1  set on any transferred result with out_ovf=1
ovf_count  output  CNT_WIDTH  count of transferred results with out_ovf=1, saturates at all-ones
clear  input  1  synchronous clear of ovf_sticky and ovf_count

Behaviour:
- Reset (rst=1 at edge): s1_valid, out_valid, ovf_sticky = 0; ovf_count = 0; diff_real, diff_imag, out_ovf = 0. In-flight samples are discarded. in_ready = 1 in the cycle after reset deasserts.
- Two register stages:
  - S1 registers the sign-extended WIDTH+1-bit differences: {a[W-1],a} - {b[W-1],b}. This cannot wrap; the range is -(2^W - 1) .. 2^W - 1.
  - S2 saturates and registers the results and out_ovf.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 sample/cycle.
- Saturation, per component, independently:
  - diff > 2^(W-1)-1 -> 0x7FFF (for W=16).
  - diff < -2^(W-1) -> 0x8000.
  - Otherwise the low W bits.
  - out_ovf is the OR of both component overflows.
- Handshake:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1. This is a combinational path from out_ready, which is accepted.
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - When adv2: S2 loads S1 contents and out_valid <= s1_valid.
  - When adv1: S1 loads inputs and s1_valid <= in_valid.
  - Stalled stages hold data and valid unchanged. No sample is dropped or duplicated.
  - out_valid, once asserted, stays high with stable data until transferred.
- Status:
  - On an output transfer with out_ovf=1: ovf_sticky <= 1 and ovf_count <= ovf_count+1, unless ovf_count is already all-ones.
  - clear=1 takes priority over a same-cycle event: ovf_sticky <= 0 and ovf_count <= 0, and the event is not counted.
  - clear does not affect the datapath.
- rst has priority over clear and over all handshakes.
- Inputs are ignored when in_ready=0 or in_valid=0.

Test Plan:
- Basic: a=(1000,-200), b=(300,50), out_ready=1 -> 2 cycles later out_valid=1, diff=(700,-250), out_ovf=0, ovf_count=0.
- Positive saturation: a=(0x7FFF,0), b=(0x8000,-32768) -> diff=(0x7FFF,0x7FFF), out_ovf=1, ovf_sticky=1, ovf_count=1.
- Negative and edge: a=(0x8000,-1), b=(1,0x7FFF) -> diff=(0x8000,0x8000), out_ovf=1. Separately, a=(0x8000,0), b=(0,0) -> diff=(0x8000,0), out_ovf=0.
- Backpressure: stream 6 samples with in_valid=1, out_ready=0 for cycles 3-6 -> in_ready drops after 2 samples are held; outputs stay stable; all 6 differences appear in order with no loss or duplicates once out_ready=1.
- Counter:
  - 260 overflowing samples -> ovf_count saturates at 255.
  - clear asserted in the same cycle as an overflowing transfer -> ovf_count=0, ovf_sticky=0 next cycle.
- Reset mid-operation: rst pulsed while 2 samples are in flight -> next cycle out_valid=0, outputs=0, in_ready=1; no stale sample emerges later.
